i2cm_rab_arb: RTL and testbench
===============================

I2CM_RAB_ARB -- requirements
Module: i2cm_rab_arb

Interface
REQ-001 Parameter TO_WIDTH, default 16, sets the ownership watchdog counter width.
REQ-002 Parameter TO_LIMIT, default 16'hFFFF, sets the idle-ownership limit in sys_clk cycles (1..2^TO_WIDTH-1).
REQ-003 sys_clk  input  1  single clock; all flops rise-edge.
REQ-004 sys_rst  input  1  asynchronous active-low reset.
REQ-005 reqN (N=0,1)  input  1  level; requester N wants bus ownership.
REQ-006 relN  input  1  one-cycle pulse; requester N releases ownership.
REQ-007 wrN / rdN  input  1 each  one-cycle access strobes from requester N; never both high together.
REQ-008 addrN  input  9  register address; wdataN  input  8  write data.
REQ-009 gntN  output  1  requester N owns the bus.
REQ-010 ackN  output  1  one-cycle access completion to requester N; rdataN  output  8  read data, valid with ackN.
REQ-011 errN  output  1  one-cycle pulse: requester N strobed without ownership, or while an access was pending.
REQ-012 rab_write / rab_read  output  1 each; rab_addr  output  9; rab_wdata  output  8  toward the i2cm_top register bus.
REQ-013 i2cm_rdata  input  8; i2cm_ack  input  1  one-cycle completion from i2cm_top.
REQ-014 to_evt  output  1  one-cycle pulse on forced watchdog release.

Function
REQ-015 States: IDLE, OWN0, OWN1; gnt0 = (state==OWN0), gnt1 = (state==OWN1), both registered.
REQ-016 IDLE: one req high -> own that requester next cycle; both high -> grant the requester that was not the last owner (round-robin); last_owner resets to 1, so requester 0 wins the first tie.
REQ-017 OWNn -> IDLE on relN, on reqN falling low, or on watchdog expiry, but only when no access is pending; otherwise the release is held until the pending ack, then taken that same cycle.
REQ-018 No direct OWN0<->OWN1 transition; IDLE lasts at least one cycle between owners.
REQ-019 Owner strobe with no access pending: register addr/wdata and drive the rab_write/rab_read pulse for exactly one cycle, one cycle after the strobe; set the pending flag.
REQ-020 Pending flag clears on i2cm_ack; the same cycle: ackN=1 and rdataN=i2cm_rdata to the owner only; the non-owner's ack and rdata stay 0.
REQ-021 Strobe from a non-owner, or from the owner while pending: not forwarded; errN pulses the next cycle.
REQ-022 i2cm_ack with no access pending: ignored; no ackN pulse.
REQ-023 rab_addr and rab_wdata hold their last value between accesses.
REQ-024 Watchdog: counter clears on grant and on every forwarded access; it increments each owned cycle with no pending access; on reaching TO_LIMIT, force release and pulse to_evt; it saturates and never wraps.
REQ-025 relN from a non-owner, and relN in IDLE, are ignored.
REQ-026 Grant, strobe and release may coincide in one cycle: release is taken and the strobe is flagged as errN, because gnt falls the next cycle.

Reset
REQ-027 While sys_rst=0: state=IDLE, last_owner=1, pending=0, counter=0, and every output is 0 (gntN, ackN, rdataN, errN, rab_*, to_evt).
REQ-028 Reset asserted mid-access drops the pending flag; a later stray i2cm_ack is ignored (REQ-022).

Verification
REQ-029 From reset, req0=req1=1 -> gnt0=1 two cycles after the req edge and gnt1=0; rel0 -> IDLE for one cycle, then gnt1=1.
REQ-030 Owner 0 write: wr0 with addr0=9'h012, wdata0=8'hA5 -> next cycle rab_write=1, rab_addr=9'h012, rab_wdata=8'hA5; i2cm_ack 3 cycles later -> ack0=1 that cycle, ack1=0.
REQ-031 Owner 1 read, i2cm_rdata=8'h3C on i2cm_ack -> rdata1=8'h3C with ack1=1; a second rd1 before the ack -> err1 pulse and no second rab_read.
REQ-032 gnt0=1, wr1 strobe -> err1=1 for one cycle; rab_write stays 0.
REQ-033 TO_LIMIT=8, owner idle -> to_evt pulse and gnt0=0 after 8 owned idle cycles; with an access pending at expiry -> release deferred until i2cm_ack.
REQ-034 Assert sys_rst=0 with an access pending -> all outputs 0 at once; after reset release, inject i2cm_ack -> no ackN.

Source files
------------

// File: rtl/i2cm_rab_arb.sv
// -----------------------------------------------------------------------------
// i2cm_rab_arb
//
// Two-requester arbiter in front of the i2cm_top register access bus (RAB).
// One requester owns the bus at a time. The owner may issue single register
// accesses. Each access completes on i2cm_ack before the owner can issue the
// next one.
//
// Handshake summary:
//   * A requester holds reqN high while it wants the bus. It sees gntN one
//     registered cycle after the arbiter state moves to its owner state.
//   * wrN/rdN are one-cycle strobes. A strobe is accepted only from the
//     current owner with no access outstanding, and only when ownership is
//     not being released in that same cycle.
//   * An accepted strobe appears on rab_write/rab_read for exactly one cycle,
//     on the cycle after the strobe. The access then stays pending until
//     i2cm_ack, which is returned combinationally as ackN/rdataN.
//   * A rejected strobe is reported by a one-cycle errN on the next cycle.
//   * relN (pulse), reqN low, or watchdog expiry release ownership. While an
//     access is pending, the release is held and taken on the acking cycle.
//
// Parameters:
//   TO_WIDTH  width of the ownership watchdog counter
//   TO_LIMIT  owned cycles with no access before ownership is revoked
//
// Ports:
//   sys_clk, sys_rst           clock, asynchronous active-low reset
//   req0/1, rel0/1             ownership request level / release pulse
//   wr0/1, rd0/1               access strobes
//   addr0/1, wdata0/1          access address / write data
//   gnt0/1                     ownership indication
//   ack0/1, rdata0/1           access completion and read data
//   err0/1                     rejected-strobe pulse
//   rab_write/read/addr/wdata  register bus toward i2cm_top
//   i2cm_rdata, i2cm_ack       register bus completion from i2cm_top
//   to_evt                     watchdog forced-release pulse
//   state_dbg                  current arbiter state (IDLE=0, OWN0=1, OWN1=2)
// -----------------------------------------------------------------------------
module i2cm_rab_arb #(
    parameter int unsigned         TO_WIDTH = 16,
    parameter logic [TO_WIDTH-1:0] TO_LIMIT = 16'hFFFF
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       rel0,
    input  logic       rel1,
    input  logic       wr0,
    input  logic       rd0,
    input  logic       wr1,
    input  logic       rd1,
    input  logic [8:0] addr0,
    input  logic [8:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       err0,
    output logic       err1,
    output logic       rab_write,
    output logic       rab_read,
    output logic [8:0] rab_addr,
    output logic [7:0] rab_wdata,
    input  logic [7:0] i2cm_rdata,
    input  logic       i2cm_ack,
    output logic       to_evt,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                last_owner;
    logic                last_owner_next;
    logic                pending;
    logic                rel_hold;
    logic [TO_WIDTH-1:0] wd_cnt;

    logic owned;
    logic own_req;
    logic own_rel;
    logic wd_exp;
    logic rel_cause;
    logic release_now;
    logic stb0;
    logic stb1;
    logic fwd0;
    logic fwd1;
    logic fwd;

    assign state_dbg = state;

    // Decode of the current owner's release conditions.
    always_comb begin
        owned     = (state != IDLE);
        own_req   = (state == OWN1) ? req1 : req0;
        own_rel   = (state == OWN1) ? rel1 : rel0;
        wd_exp    = (wd_cnt == TO_LIMIT);
        rel_cause = owned & (own_rel | ~own_req | wd_exp);
        // A pending access pins ownership; the release (new or held) is
        // taken on the very cycle the access is acknowledged.
        if (pending) begin
            release_now = i2cm_ack & (rel_cause | rel_hold);
        end else begin
            release_now = rel_cause;
        end
    end

    // Strobe acceptance. A strobe coinciding with a release is rejected
    // because the requester loses the bus on that edge.
    always_comb begin
        stb0 = wr0 | rd0;
        stb1 = wr1 | rd1;
        fwd0 = stb0 & (state == OWN0) & ~pending & ~release_now;
        fwd1 = stb1 & (state == OWN1) & ~pending & ~release_now;
        fwd  = fwd0 | fwd1;
    end

    // Completion is steered to the owner only; stray acks are dropped.
    always_comb begin
        ack0   = i2cm_ack & pending & (state == OWN0);
        ack1   = i2cm_ack & pending & (state == OWN1);
        rdata0 = ack0 ? i2cm_rdata : 8'h00;
        rdata1 = ack1 ? i2cm_rdata : 8'h00;
    end

    // Next-state logic. Owners always pass through IDLE, so there is at
    // least one cycle between two grants.
    always_comb begin
        state_next      = state;
        last_owner_next = last_owner;
        case (state)
            IDLE: begin
                // On a tie the requester that did not own last wins.
                if (req0 && (!req1 || last_owner)) begin
                    state_next      = OWN0;
                    last_owner_next = 1'b0;
                end else if (req1) begin
                    state_next      = OWN1;
                    last_owner_next = 1'b1;
                end
            end
            OWN0, OWN1: begin
                if (release_now) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
        end else begin
            state      <= state_next;
            last_owner <= last_owner_next;
        end
    end

    // Access tracking and watchdog.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            pending  <= 1'b0;
            rel_hold <= 1'b0;
            wd_cnt   <= '0;
        end else begin
            if (fwd) begin
                pending <= 1'b1;
            end else if (i2cm_ack) begin
                pending <= 1'b0;
            end
            rel_hold <= pending & ~i2cm_ack & (rel_hold | rel_cause);
            // The counter stays cleared in IDLE, so a new grant starts at 0.
            // It stops at TO_LIMIT and never wraps.
            if (!owned || release_now || fwd) begin
                wd_cnt <= '0;
            end else if (!pending && !wd_exp) begin
                wd_cnt <= wd_cnt + TO_WIDTH'(1);
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rab_write <= 1'b0;
            rab_read  <= 1'b0;
            rab_addr  <= 9'h000;
            rab_wdata <= 8'h00;
            to_evt    <= 1'b0;
        end else begin
            gnt0      <= (state == OWN0);
            gnt1      <= (state == OWN1);
            err0      <= stb0 & ~fwd0;
            err1      <= stb1 & ~fwd1;
            rab_write <= fwd0 ? wr0 : (fwd1 & wr1);
            rab_read  <= fwd0 ? rd0 : (fwd1 & rd1);
            if (fwd) begin
                rab_addr  <= fwd0 ? addr0 : addr1;
                rab_wdata <= fwd0 ? wdata0 : wdata1;
            end
            to_evt    <= release_now & wd_exp;
        end
    end

endmodule

// File: tb/tb_i2cm_rab_arb.sv
// -----------------------------------------------------------------------------
// tb_i2cm_rab_arb
//
// Bench for i2cm_rab_arb with a short watchdog (TO_LIMIT = 8). A behavioural
// model tracks owner, outstanding access and idle-ownership cycles, and is
// compared with the DUT every falling edge. Forwarded accesses go through an
// expected queue. Directed sequences reproduce the documented scenarios with
// explicit checks; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_i2cm_rab_arb;

  localparam int TO_LIMIT = 8;
  localparam int W        = 19;  // {write, read, addr[8:0], wdata[7:0]}

  // ---------------------------------------------------------------- clock/reset
  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  logic       req0, req1, rel0, rel1, wr0, rd0, wr1, rd1;
  logic [8:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, ack0, ack1, err0, err1;
  logic [7:0] rdata0, rdata1;
  logic       rab_write, rab_read;
  logic [8:0] rab_addr;
  logic [7:0] rab_wdata;
  logic [7:0] i2cm_rdata;
  logic       i2cm_ack;
  logic       to_evt;
  logic [1:0] state_dbg;

  i2cm_rab_arb #(
    .TO_WIDTH (16),
    .TO_LIMIT (16'd8)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .req0       (req0),
    .req1       (req1),
    .rel0       (rel0),
    .rel1       (rel1),
    .wr0        (wr0),
    .rd0        (rd0),
    .wr1        (wr1),
    .rd1        (rd1),
    .addr0      (addr0),
    .addr1      (addr1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .ack0       (ack0),
    .ack1       (ack1),
    .rdata0     (rdata0),
    .rdata1     (rdata1),
    .err0       (err0),
    .err1       (err1),
    .rab_write  (rab_write),
    .rab_read   (rab_read),
    .rab_addr   (rab_addr),
    .rab_wdata  (rab_wdata),
    .i2cm_rdata (i2cm_rdata),
    .i2cm_ack   (i2cm_ack),
    .to_evt     (to_evt),
    .state_dbg  (state_dbg)
  );

  // ---------------------------------------------------------------- checking
  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt0"}, gnt0, 0);
    check({tag, "_gnt1"}, gnt1, 0);
    check({tag, "_ack0"}, ack0, 0);
    check({tag, "_ack1"}, ack1, 0);
    check({tag, "_rdata0"}, rdata0, 0);
    check({tag, "_rdata1"}, rdata1, 0);
    check({tag, "_err0"}, err0, 0);
    check({tag, "_err1"}, err1, 0);
    check({tag, "_rab_write"}, rab_write, 0);
    check({tag, "_rab_read"}, rab_read, 0);
    check({tag, "_rab_addr"}, rab_addr, 0);
    check({tag, "_rab_wdata"}, rab_wdata, 0);
    check({tag, "_to_evt"}, to_evt, 0);
  endtask

  // ---------------------------------------------------------------- reference model
  // Owner is -1 when nobody holds the bus. m_gnt is the owner as seen on gnt,
  // which follows the arbiter one clock later.
  int         m_owner, m_gnt, m_idle, m_last;
  bit         m_busy, m_hold, m_err0, m_err1, m_to;
  logic [8:0] m_addr;
  logic [7:0] m_wdata;
  logic [W-1:0] exp_q[$];

  task automatic model_step();
    logic rq [0:1];
    logic rl [0:1];
    logic st [0:1];
    bit   busy_was, expired, released, want;
    int   fwd;
    rq[0] = req0;        rq[1] = req1;
    rl[0] = rel0;        rl[1] = rel1;
    st[0] = wr0 | rd0;   st[1] = wr1 | rd1;
    busy_was = m_busy;
    expired  = (m_owner >= 0) && (m_idle >= TO_LIMIT);
    released = 1'b0;
    m_gnt    = m_owner;
    m_err0   = 1'b0;
    m_err1   = 1'b0;

    if (m_owner >= 0) begin
      want = rl[m_owner] || !rq[m_owner] || expired;
      if (busy_was) begin
        if (i2cm_ack) begin
          m_busy   = 1'b0;
          released = want || m_hold;
          m_hold   = 1'b0;
        end else if (want) begin
          m_hold = 1'b1;
        end
      end else begin
        released = want;
      end
    end
    m_to = released && expired;

    fwd = -1;
    for (int x = 0; x < 2; x++) begin
      if (st[x]) begin
        if (m_owner == x && !busy_was && !released) begin
          fwd     = x;
          m_busy  = 1'b1;
          m_addr  = (x == 0) ? addr0 : addr1;
          m_wdata = (x == 0) ? wdata0 : wdata1;
          exp_q.push_back({(x == 0) ? wr0 : wr1, (x == 0) ? rd0 : rd1, m_addr, m_wdata});
        end else if (x == 0) begin
          m_err0 = 1'b1;
        end else begin
          m_err1 = 1'b1;
        end
      end
    end

    if (m_owner >= 0 && !released) begin
      if (fwd >= 0) m_idle = 0;
      else if (!busy_was && m_idle < TO_LIMIT) m_idle++;
    end else begin
      m_idle = 0;
    end

    if (released) begin
      m_owner = -1;
    end else if (m_owner < 0 && (rq[0] || rq[1])) begin
      m_owner = (rq[0] && rq[1]) ? (1 - m_last) : (rq[0] ? 0 : 1);
      m_last  = m_owner;
    end
  endtask

  always @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      m_owner = -1;
      m_gnt   = -1;
      m_idle  = 0;
      m_last  = 1;
      m_busy  = 1'b0;
      m_hold  = 1'b0;
      m_err0  = 1'b0;
      m_err1  = 1'b0;
      m_to    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      exp_q.delete();
    end else begin
      model_step();
    end
  end

  // Per-cycle scoreboard, sampled away from the active edge.
  always @(negedge sys_clk) begin
    if (chk_en) begin
      logic [W-1:0] e;
      logic         ea0, ea1;
      ea0 = i2cm_ack && m_busy && (m_owner == 0);
      ea1 = i2cm_ack && m_busy && (m_owner == 1);
      check("gnt0", gnt0, m_gnt == 0);
      check("gnt1", gnt1, m_gnt == 1);
      check("err0", err0, m_err0);
      check("err1", err1, m_err1);
      check("to_evt", to_evt, m_to);
      check("ack0", ack0, ea0);
      check("ack1", ack1, ea1);
      check("rdata0", rdata0, ea0 ? i2cm_rdata : 8'h00);
      check("rdata1", rdata1, ea1 ? i2cm_rdata : 8'h00);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rab_write", rab_write, e[18]);
        check("rab_read", rab_read, e[17]);
        check("rab_addr", rab_addr, e[16:8]);
        check("rab_wdata", rab_wdata, e[7:0]);
      end else begin
        check("rab_write_idle", rab_write, 0);
        check("rab_read_idle", rab_read, 0);
        check("rab_addr_hold", rab_addr, m_addr);
        check("rab_wdata_hold", rab_wdata, m_wdata);
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    req0 = 0; req1 = 0; rel0 = 0; rel1 = 0;
    wr0 = 0; rd0 = 0; wr1 = 0; rd1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    i2cm_rdata = '0; i2cm_ack = 0;
  endtask

  task automatic random_cycle();
    int r;
    if ($urandom_range(0, 15) == 0) req0 = ~req0;
    if ($urandom_range(0, 15) == 0) req1 = ~req1;
    rel0 = ($urandom_range(0, 19) == 0);
    rel1 = ($urandom_range(0, 19) == 0);
    r = $urandom_range(0, 9);
    wr0 = (r == 0);
    rd0 = (r == 1);
    r = $urandom_range(0, 9);
    wr1 = (r == 0);
    rd1 = (r == 1);
    addr0  = 9'($urandom_range(0, 511));
    addr1  = 9'($urandom_range(0, 511));
    wdata0 = 8'($urandom_range(0, 255));
    wdata1 = 8'($urandom_range(0, 255));
    i2cm_ack   = ($urandom_range(0, 3) == 0);
    i2cm_rdata = 8'($urandom_range(0, 255));
    step();
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    clear_inputs();
    sys_rst = 1'b0;
    step();
    chk_en = 1'b1;
    check_all_zero("reset");
    step(2);
    sys_rst = 1'b1;

    // Tie from reset: requester 0 wins, gnt two edges after req.
    req0 = 1; req1 = 1;
    step();
    check("tie_gnt0_early", gnt0, 0);
    step();
    check("tie_gnt0", gnt0, 1);
    check("tie_gnt1", gnt1, 0);
    rel0 = 1;
    step();
    rel0 = 0;
    step();
    check("rr_gap_gnt0", gnt0, 0);
    check("rr_gap_gnt1", gnt1, 0);
    step();
    check("rr_gnt1", gnt1, 1);

    // Owner 1 read, then a second read while pending.
    rd1 = 1; addr1 = 9'h055;
    step();
    check("rd1_rab_read", rab_read, 1);
    check("rd1_rab_addr", rab_addr, 9'h055);
    step();
    rd1 = 0;
    check("rd1_busy_err1", err1, 1);
    check("rd1_busy_no_read", rab_read, 0);
    i2cm_rdata = 8'h3C; i2cm_ack = 1;
    #1;
    check("rd1_ack1", ack1, 1);
    check("rd1_rdata1", rdata1, 8'h3C);
    check("rd1_ack0", ack0, 0);
    check("rd1_rdata0", rdata0, 0);
    step();
    i2cm_ack = 0;

    // Owner 1 drops req; requester 0 takes over.
    req1 = 0;
    step(3);
    check("hand_gnt0", gnt0, 1);
    check("hand_gnt1", gnt1, 0);

    // Non-owner strobe.
    wr1 = 1; addr1 = 9'h1FF; wdata1 = 8'hEE;
    step();
    wr1 = 0;
    check("nonowner_err1", err1, 1);
    check("nonowner_no_write", rab_write, 0);

    // Owner 0 write.
    wr0 = 1; addr0 = 9'h012; wdata0 = 8'hA5;
    step();
    wr0 = 0;
    check("wr0_rab_write", rab_write, 1);
    check("wr0_rab_addr", rab_addr, 9'h012);
    check("wr0_rab_wdata", rab_wdata, 8'hA5);
    step(2);
    check("wr0_single_pulse", rab_write, 0);
    i2cm_ack = 1;
    #1;
    check("wr0_ack0", ack0, 1);
    check("wr0_ack1", ack1, 0);
    step();
    i2cm_ack = 0;
    step();
    check("addr_hold", rab_addr, 9'h012);

    // Release requested while an access is pending is deferred to the ack.
    wr0 = 1; addr0 = 9'h100; wdata0 = 8'h5A;
    step();
    wr0 = 0; rel0 = 1;
    step();
    rel0 = 0;
    step(2);
    check("defer_gnt0", gnt0, 1);
    i2cm_ack = 1; i2cm_rdata = 8'h77;
    #1;
    check("defer_ack0", ack0, 1);
    check("defer_rdata0", rdata0, 8'h77);
    step();
    i2cm_ack = 0;
    step();
    check("defer_released", gnt0, 0);
    req0 = 0;
    step(3);

    // Watchdog on an idle owner.
    req1 = 1;
    step();
    step(8);
    check("wd_no_evt_yet", to_evt, 0);
    step();
    check("wd_to_evt", to_evt, 1);
    check("wd_gnt1_still", gnt1, 1);
    step();
    check("wd_to_evt_pulse", to_evt, 0);
    check("wd_gnt1_off", gnt1, 0);
    req1 = 0;
    step(3);

    // Strobe coinciding with release is rejected.
    req0 = 1;
    step(2);
    wr0 = 1; rel0 = 1; addr0 = 9'h0AA;
    step();
    wr0 = 0; rel0 = 0;
    check("coinc_err0", err0, 1);
    check("coinc_no_write", rab_write, 0);
    step(2);

    // Reset during a pending access, then a stray ack.
    wr0 = 1; addr0 = 9'h033; wdata0 = 8'h44;
    step();
    wr0 = 0;
    step();
    sys_rst = 1'b0;
    i2cm_ack = 1;
    #1;
    check_all_zero("midreset");
    i2cm_ack = 0; req0 = 0;
    step(2);
    sys_rst = 1'b1;
    step();
    i2cm_ack = 1;
    #1;
    check("stray_ack0", ack0, 0);
    check("stray_ack1", ack1, 0);
    step();
    i2cm_ack = 0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      random_cycle();
    end
    clear_inputs();
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
